nor_stage_sequencer: RTL and testbench



---
 rtl/nor_stage_sequencer.sv | 102 ++++++++++
 tb/tb_nor_stage_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_stage_sequencer.sv
// Feeds a `_nor` gate array: assembles a serial operand, holds it for a settle
// window, then captures the NOR result and offers it on a valid/ready port.
module nor_stage_sequencer #(
  parameter int INPUT_WIDTH   = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   serialIn,
  input  logic                   serialValid,
  output logic                   serialReady,
  output logic [INPUT_WIDTH-1:0] norInput,
  input  logic                   norOutput,
  output logic                   resultData,
  output logic                   resultValid,
  input  logic                   resultReady,
  output logic                   busy,
  output logic [1:0]             stateDbg
);

  localparam int BW = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(INPUT_WIDTH - 1);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                 state;
  logic [BW-1:0]          bitCount;
  logic [INPUT_WIDTH-1:0] shiftReg;
  logic [INPUT_WIDTH-1:0] assembled;
  logic [CW-1:0]          settleCount;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid must not depend on ready, and ready here is a pure
  // function of the registered state.
  assign serialReady = (state == LOAD);
  assign busy        = (state != LOAD);
  assign resultValid = (state == HOLD);
  assign stateDbg    = state;

  // Shift register with the incoming bit already merged, so the final bit
  // lands in norInput on the same edge that completes the operand.
  always_comb begin
    assembled           = shiftReg;
    assembled[bitCount] = serialIn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      bitCount    <= '0;
      shiftReg    <= '0;
      norInput    <= '0;
      resultData  <= 1'b0;
      settleCount <= '0;
    end else if (clear) begin
      state       <= LOAD;
      bitCount    <= '0;
      shiftReg    <= '0;
      settleCount <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (serialValid) begin
            if (bitCount == LAST_BIT) begin
              norInput    <= assembled;
              shiftReg    <= '0;
              bitCount    <= '0;
              settleCount <= SETTLE_INIT;
              state       <= SETTLE;
            end else begin
              shiftReg <= assembled;
              bitCount <= bitCount + 1'b1;
            end
          end
        end
        SETTLE: begin
          settleCount <= settleCount - 1'b1;
          if (settleCount == CW'(1)) begin
            resultData <= norOutput;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (resultReady) begin
            state <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nor_stage_sequencer.sv
// Self-checking bench for nor_stage_sequencer driving an ideal 4-input NOR
// as the attached gate array.
module tb_nor_stage_sequencer;

  localparam int W = 4;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         serialIn = 1'b0;
  logic         serialValid = 1'b0;
  logic         serialReady;
  logic [W-1:0] norInput;
  logic         norOutput;
  logic         resultData;
  logic         resultValid;
  logic         resultReady = 1'b0;
  logic         busy;
  logic [1:0]   stateDbg;

  int total = 0;
  int bad = 0;
  int hsCount = 0;

  logic [W:0] exp_q[$];

  nor_stage_sequencer #(.INPUT_WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .serialIn(serialIn), .serialValid(serialValid), .serialReady(serialReady),
    .norInput(norInput), .norOutput(norOutput),
    .resultData(resultData), .resultValid(resultValid), .resultReady(resultReady),
    .busy(busy), .stateDbg(stateDbg)
  );

  // Ideal NOR array: output high only when every input bit is low.
  assign norOutput = (norInput == '0);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && resultValid && resultReady) hsCount <= hsCount + 1;
  end

  typedef struct {
    logic [W-1:0] word;
    logic         expNor;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    serialValid = 1'b1;
    serialIn    = b;
    step();
    serialValid = 1'b0;
  endtask

  task automatic sendWord(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) sendBit(w[i]);
  endtask

  // Returns the number of edges until resultValid is seen, or -1 on timeout.
  task automatic waitResult(output int cycles);
    cycles = 0;
    while (!resultValid && cycles < 30) begin
      step();
      cycles++;
    end
    if (!resultValid) cycles = -1;
  endtask

  task automatic handshake();
    resultReady = 1'b1;
    step();
    resultReady = 1'b0;
  endtask

  int lat;
  int hsBefore;
  logic stable;
  logic [W:0] expRec;
  logic [W-1:0] w;

  initial begin
    vecs[0] = '{word: 4'b0000, expNor: 1'b1};
    vecs[1] = '{word: 4'b0101, expNor: 1'b0};
    vecs[2] = '{word: 4'b1000, expNor: 1'b0};
    vecs[3] = '{word: 4'b0001, expNor: 1'b0};
    vecs[4] = '{word: 4'b1111, expNor: 1'b0};
    vecs[5] = '{word: 4'b0000, expNor: 1'b1};

    // Reset block
    #12 rst_n = 1'b1;
    step();
    check("reset_norInput", norInput, 0);
    check("reset_resultValid", resultValid, 0);
    check("reset_serialReady", serialReady, 1);
    check("reset_busy", busy, 0);

    // Table-driven operands, back-to-back bits
    foreach (vecs[k]) begin
      sendWord(vecs[k].word);
      check("vec_norInput", norInput, vecs[k].word);
      check("vec_serialReady_settle", serialReady, 0);
      check("vec_busy_settle", busy, 1);
      waitResult(lat);
      check("vec_latency", lat, S);
      check("vec_resultData", resultData, vecs[k].expNor);
      check("vec_serialReady_hold", serialReady, 0);
      handshake();
      check("vec_back_to_load", serialReady, 1);
      check("vec_resultValid_drop", resultValid, 0);
    end

    // resultReady held high before HOLD: completes in the first HOLD cycle
    resultReady = 1'b1;
    hsBefore = hsCount;
    sendWord(4'b0101);
    waitResult(lat);
    check("early_ready_latency", lat, S);
    check("early_ready_data", resultData, 0);
    step();
    check("early_ready_load", serialReady, 1);
    check("early_ready_one_hs", hsCount - hsBefore, 1);
    sendWord(4'b0000);
    waitResult(lat);
    step();
    check("early_ready_next_data", resultData, 1);
    resultReady = 1'b0;

    // Backpressure with ignored serial pulses during HOLD
    sendWord(4'b0010);
    waitResult(lat);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      serialValid = i[0];
      serialIn    = 1'b1;
      step();
      if (!resultValid || resultData !== 1'b0 || norInput !== 4'b0010) stable = 1'b0;
    end
    serialValid = 1'b0;
    check("bp_stable", stable, 1);
    hsBefore = hsCount;
    handshake();
    check("bp_one_hs", hsCount - hsBefore, 1);
    check("bp_load", serialReady, 1);
    for (int i = 0; i < W - 1; i++) sendBit(1'b0);
    check("bp_no_stray_bits", busy, 0);
    sendBit(1'b0);
    check("bp_operand_done", busy, 1);
    waitResult(lat);
    check("bp_result", resultData, 1);
    handshake();

    // Gaps in serialValid
    sendBit(1'b1);
    sendBit(1'b1);
    repeat (5) step();
    check("gap_not_busy", busy, 0);
    sendBit(1'b0);
    sendBit(1'b1);
    check("gap_norInput", norInput, 4'b1011);
    waitResult(lat);
    check("gap_result", resultData, 0);
    handshake();

    // Clear mid-operand: the bit in the clear cycle is dropped
    sendWord(4'b0110);
    waitResult(lat);
    handshake();
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b1);
    clear = 1'b1;
    serialValid = 1'b1;
    serialIn = 1'b1;
    step();
    clear = 1'b0;
    serialValid = 1'b0;
    check("clear_norInput_kept", norInput, 4'b0110);
    check("clear_ready", serialReady, 1);
    sendBit(1'b0);
    check("clear_bitcount_zero", busy, 0);
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b0);
    check("clear_fresh_operand", norInput, 4'b0000);
    waitResult(lat);
    check("clear_fresh_result", resultData, 1);
    handshake();

    // Clear while HOLD
    sendWord(4'b0000);
    waitResult(lat);
    hsBefore = hsCount;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_hold_valid", resultValid, 0);
    check("clear_hold_data_kept", resultData, 1);
    check("clear_hold_no_hs", hsCount - hsBefore, 0);
    check("clear_hold_load", serialReady, 1);

    // Reset asserted mid-cycle during SETTLE
    sendWord(4'b1111);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_norInput", norInput, 0);
    check("rst_resultValid", resultValid, 0);
    check("rst_serialReady", serialReady, 1);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (resultValid || busy) stable = 1'b0;
    end
    check("rst_no_result", stable, 1);

    // Randomized operands against the scoreboard
    for (int n = 0; n < 30; n++) begin
      w = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      exp_q.push_back({w, (w == 4'b0000)});
      resultReady = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < W; i++) begin
        while ($urandom_range(0, 3) == 0) step();
        sendBit(w[i]);
      end
      waitResult(lat);
      check("rand_latency", lat, S);
      if (!resultReady) repeat ($urandom_range(0, 3)) step();
      expRec = exp_q.pop_front();
      check("rand_norInput", norInput, expRec[W:1]);
      check("rand_resultData", resultData, expRec[0]);
      if (resultReady) step();
      else handshake();
      resultReady = 1'b0;
      check("rand_back_to_load", serialReady, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
